// File: rtl/plca_rx_cmd_decoder.sv
// PLCA receive command decoder: qualifies BEACON/COMMIT symbols from MII RX and drives rx_cmd/receiving/CRS.
// Optional saturating command statistics are built only when PLCA_RX_STATS_EN is defined.
module plca_rx_cmd_decoder #(
  parameter int MIN_SYM = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             plca_en,
  input  logic             plca_reset,
  input  logic             RX_DV,
  input  logic             RX_ER,
  input  logic [3:0]       RXD,
  input  logic             PHY_CRS,
  output logic [1:0]       rx_cmd,
  output logic             receiving,
  output logic             CRS,
  output logic             cmd_err,
  output logic [CNT_W-1:0] beacon_cnt,
  output logic [CNT_W-1:0] commit_cnt
);

  typedef enum logic [2:0] {IDLE, QUAL, BEACON, COMMIT, DATA} state_t;

  localparam logic [1:0] CMD_BEACON = 2'b00;
  localparam logic [1:0] CMD_COMMIT = 2'b01;
  localparam logic [1:0] CMD_NONE   = 2'b10;
  localparam logic [3:0] MIN4       = 4'(MIN_SYM);

  state_t     state_q, state_d;
  logic [3:0] qual_q, qual_d;
  logic       pend_q, pend_d;   // 0 = beacon pending, 1 = commit pending
  logic       err_d;
  logic [1:0] rx_cmd_q;
  logic       receiving_q, crs_q, cmd_err_q;

  logic rst, bcn, cmt, dat, is_cmd, sym_t;

  assign rst    = reset | plca_reset | ~plca_en;
  assign bcn    = ~RX_DV & RX_ER & (RXD == 4'h2);
  assign cmt    = ~RX_DV & RX_ER & (RXD == 4'h3);
  assign dat    = RX_DV;
  assign is_cmd = bcn | cmt;
  assign sym_t  = cmt;

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    if (dat) begin
      state_d = DATA;
      qual_d  = 4'd0;
    end else begin
      unique case (state_q)
        IDLE, DATA: begin
          state_d = IDLE;
          qual_d  = 4'd0;
          if (is_cmd) begin
            if (MIN_SYM == 1) begin
              state_d = sym_t ? COMMIT : BEACON;
            end else begin
              state_d = QUAL;
              qual_d  = 4'd1;
              pend_d  = sym_t;
            end
          end
        end
        QUAL: begin
          if (!is_cmd) begin
            state_d = IDLE;
            qual_d  = 4'd0;
            err_d   = 1'b1;
          end else if (sym_t == pend_q) begin
            qual_d = qual_q + 4'd1;
            if (qual_q + 4'd1 >= MIN4) begin
              state_d = pend_q ? COMMIT : BEACON;
              qual_d  = MIN4;
            end
          end else begin
            qual_d = 4'd1;
            pend_d = sym_t;
          end
        end
        BEACON, COMMIT: begin
          if (!is_cmd) begin
            state_d = IDLE;
            qual_d  = 4'd0;
          end else if (sym_t != (state_q == COMMIT)) begin
            // a single-symbol qualifier switches command directly
            if (MIN_SYM == 1) begin
              state_d = sym_t ? COMMIT : BEACON;
            end else begin
              state_d = QUAL;
              qual_d  = 4'd1;
              pend_d  = sym_t;
            end
          end
        end
        default: begin
          state_d = IDLE;
          qual_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      qual_q      <= 4'd0;
      pend_q      <= 1'b0;
      rx_cmd_q    <= CMD_NONE;
      receiving_q <= 1'b0;
      crs_q       <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      qual_q      <= qual_d;
      pend_q      <= pend_d;
      rx_cmd_q    <= (state_d == BEACON) ? CMD_BEACON :
                     (state_d == COMMIT) ? CMD_COMMIT : CMD_NONE;
      receiving_q <= (state_d == DATA);
      crs_q       <= PHY_CRS | (state_d == BEACON) | (state_d == COMMIT) | (state_d == DATA);
      cmd_err_q   <= err_d;
    end
  end

  assign rx_cmd    = rx_cmd_q;
  assign receiving = receiving_q;
  assign CRS       = crs_q;
  assign cmd_err   = cmd_err_q;

`ifdef PLCA_RX_STATS_EN
  logic [CNT_W-1:0] bcnt_q, ccnt_q;
  logic             bcn_entry, cmt_entry;

  assign bcn_entry = (state_d == BEACON) & (state_q != BEACON);
  assign cmt_entry = (state_d == COMMIT) & (state_q != COMMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (bcn_entry && !(&bcnt_q)) bcnt_q <= bcnt_q + 1'b1;
      if (cmt_entry && !(&ccnt_q)) ccnt_q <= ccnt_q + 1'b1;
    end
  end

  assign beacon_cnt = bcnt_q;
  assign commit_cnt = ccnt_q;
`else
  assign beacon_cnt = '0;
  assign commit_cnt = '0;
`endif

endmodule

// File: tb/tb_plca_rx_cmd_decoder.sv
// Directed bench for plca_rx_cmd_decoder (MIN_SYM=2, CNT_W=4); counter expectations follow PLCA_RX_STATS_EN.
module tb_plca_rx_cmd_decoder;

`ifdef PLCA_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, plca_en, plca_reset, RX_DV, RX_ER, PHY_CRS;
  logic [3:0] RXD;
  logic [1:0] rx_cmd;
  logic       receiving, CRS, cmd_err;
  logic [3:0] beacon_cnt, commit_cnt;

  int n_run = 0;
  int n_fail = 0;

  plca_rx_cmd_decoder #(.MIN_SYM(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .plca_en(plca_en), .plca_reset(plca_reset),
    .RX_DV(RX_DV), .RX_ER(RX_ER), .RXD(RXD), .PHY_CRS(PHY_CRS),
    .rx_cmd(rx_cmd), .receiving(receiving), .CRS(CRS), .cmd_err(cmd_err),
    .beacon_cnt(beacon_cnt), .commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sym_bcn(); RX_DV = 0; RX_ER = 1; RXD = 4'h2; tick(); endtask
  task automatic sym_cmt(); RX_DV = 0; RX_ER = 1; RXD = 4'h3; tick(); endtask
  task automatic sym_q();   RX_DV = 0; RX_ER = 0; RXD = 4'h0; tick(); endtask
  task automatic sym_dat(input logic er, input logic [3:0] d); RX_DV = 1; RX_ER = er; RXD = d; tick(); endtask

  logic err_seen;
  int   rcv_cnt;

  initial begin
    reset = 1; plca_en = 1; plca_reset = 0; RX_DV = 0; RX_ER = 0; RXD = 0; PHY_CRS = 0;
    tick(); tick();
    chk("rst_rx_cmd", rx_cmd, 2'b10);
    chk("rst_recv", receiving, 0);
    chk("rst_crs", CRS, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_bcnt", beacon_cnt, 0);
    chk("rst_ccnt", commit_cnt, 0);
    reset = 0;
    sym_q();

    // 5 beacon symbols: qualifies on 2nd, holds through 5th
    sym_bcn();
    chk("bcn1_cmd", rx_cmd, 2'b10);
    chk("bcn1_crs", CRS, 0);
    for (int i = 2; i <= 5; i++) begin
      sym_bcn();
      chk($sformatf("bcn%0d_cmd", i), rx_cmd, 2'b00);
      chk($sformatf("bcn%0d_crs", i), CRS, 1);
    end
    sym_q();
    chk("bcn_end_cmd", rx_cmd, 2'b10);
    chk("bcn_end_crs", CRS, 0);
    chk("bcn_cnt1", beacon_cnt, STATS ? 1 : 0);

    // lone beacon symbol fails qualification
    sym_bcn();
    chk("lone_cmd", rx_cmd, 2'b10);
    chk("lone_err0", cmd_err, 0);
    sym_q();
    chk("lone_err1", cmd_err, 1);
    chk("lone_cmd2", rx_cmd, 2'b10);
    sym_q();
    chk("lone_err2", cmd_err, 0);
    chk("lone_bcnt", beacon_cnt, STATS ? 1 : 0);

    // commit then 64-cycle frame with RX_ER noise
    sym_cmt();
    chk("cmt1_cmd", rx_cmd, 2'b10);
    sym_cmt();
    chk("cmt2_cmd", rx_cmd, 2'b01);
    sym_cmt();
    chk("cmt3_cmd", rx_cmd, 2'b01);
    chk("cmt3_crs", CRS, 1);
    rcv_cnt = 0;
    err_seen = 0;
    for (int i = 0; i < 64; i++) begin
      sym_dat(i[0], 4'h2);
      if (i == 0) chk("dat0_cmd", rx_cmd, 2'b10);
      if (receiving && rx_cmd == 2'b10 && CRS) rcv_cnt++;
      err_seen |= cmd_err;
    end
    chk("dat_rcv_cycles", rcv_cnt, 64);
    chk("dat_no_err", err_seen, 0);
    sym_q();
    chk("dat_end_recv", receiving, 0);
    chk("dat_end_crs", CRS, 0);
    chk("cmt_cnt1", commit_cnt, STATS ? 1 : 0);

    // beacon to commit switch
    err_seen = 0;
    sym_bcn(); err_seen |= cmd_err;
    sym_bcn(); err_seen |= cmd_err;
    chk("sw_b", rx_cmd, 2'b00);
    sym_cmt(); err_seen |= cmd_err;
    chk("sw_c1", rx_cmd, 2'b10);
    sym_cmt(); err_seen |= cmd_err;
    chk("sw_c2", rx_cmd, 2'b01);
    sym_q(); err_seen |= cmd_err;
    chk("sw_no_err", err_seen, 0);
    chk("sw_bcnt", beacon_cnt, STATS ? 2 : 0);
    chk("sw_ccnt", commit_cnt, STATS ? 2 : 0);

    // beacon right after a frame starts qualification
    sym_dat(0, 4'h5);
    chk("fb_recv", receiving, 1);
    sym_bcn();
    chk("fb_recv0", receiving, 0);
    chk("fb_cmd0", rx_cmd, 2'b10);
    sym_bcn();
    chk("fb_cmd1", rx_cmd, 2'b00);
    chk("fb_bcnt", beacon_cnt, STATS ? 3 : 0);

    // disable mid-beacon, then requalify
    plca_en = 0;
    sym_bcn();
    chk("dis_cmd", rx_cmd, 2'b10);
    chk("dis_crs", CRS, 0);
    chk("dis_bcnt", beacon_cnt, 0);
    chk("dis_ccnt", commit_cnt, 0);
    plca_en = 1;
    sym_bcn();
    chk("ren_cmd1", rx_cmd, 2'b10);
    sym_bcn();
    chk("ren_cmd2", rx_cmd, 2'b00);
    chk("ren_bcnt", beacon_cnt, STATS ? 1 : 0);

    // management reset mid-beacon
    plca_reset = 1;
    sym_bcn();
    chk("mrst_cmd", rx_cmd, 2'b10);
    plca_reset = 0;
    sym_q();

    // PHY carrier passes straight through
    PHY_CRS = 1;
    sym_q();
    chk("phy_crs1", CRS, 1);
    chk("phy_crs_cmd", rx_cmd, 2'b10);
    PHY_CRS = 0;
    sym_q();
    chk("phy_crs0", CRS, 0);

    // saturation: 2^4+3 beacons
    for (int i = 1; i <= 19; i++) begin
      sym_bcn(); sym_bcn(); sym_q();
      if (i == 14) chk("sat_14", beacon_cnt, STATS ? 14 : 0);
    end
    chk("sat_19", beacon_cnt, STATS ? 15 : 0);
    chk("sat_ccnt", commit_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
